level_port_arbiter: RTL

Shares a single level-tile lookup port between the three clients that need it: display tile fetch, player collision probe and blade collision probe. It sits between `collision_resolver`/`display_controller` and `level`, so `level` needs one read port instead of three. The block provides a req/gnt handshake, a fixed display priority with a starvation guard, round-robin between the two collision probes, and a two-stage pipelined return path tagged per requester.

---
 rtl/lvl_arb_pkg.sv | 18 +
 rtl/lvl_rr_pick.sv | 25 ++
 rtl/level_port_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lvl_arb_pkg.sv
// Shared constants for the level-tile lookup port arbiter.
package lvl_arb_pkg;

    // Requester IDs: bit positions within req/gnt/rvalid.
    localparam int REQ_DISP = 0;
    localparam int REQ_PLY  = 1;
    localparam int REQ_BLD  = 2;

    // Default widths and starvation limit.
    localparam int DEF_CW       = 10;
    localparam int DEF_TW       = 3;
    localparam int DEF_MAX_WAIT = 8;

    // Wait counters cover MAX_WAIT up to 255; grant counters are 16 bits.
    localparam int WAIT_W = 8;
    localparam int STAT_W = 16;

endpackage

// File: rtl/lvl_rr_pick.sv
// Two-input round-robin picker shared by the normal collision path and the
// both-saturated starvation path. ptr=0 favours input A (player),
// ptr=1 favours input B (blade). nextPtr moves past the winner.
module lvl_rr_pick (
    input  logic       reqA,
    input  logic       reqB,
    input  logic       ptr,
    output logic [1:0] win,
    output logic       nextPtr
);

    // Pick A unless B also requests and the pointer favours B.
    always_comb begin
        win     = 2'b00;
        nextPtr = ptr;
        if (reqA && (!reqB || !ptr)) begin
            win     = 2'b01;
            nextPtr = 1'b1;
        end else if (reqB) begin
            win     = 2'b10;
            nextPtr = 1'b0;
        end
    end

endmodule

// File: rtl/level_port_arbiter.sv
// Shares one level-tile lookup port between display fetch, player probe and
// blade probe. Display has fixed priority, guarded by per-probe starvation
// counters; the two probes alternate round-robin. Results return two cycles
// after the grant, tagged with a one-hot rvalid.
// Optional grant statistics: define LVL_ARB_STATS_EN.
//
// Handshake: a requester raises req[i] with its x/y and holds all three
// stable until it sees gnt[i] (combinational, same cycle). req[i] still high
// in the cycle after gnt[i] is a fresh request. rvalid[i] pulses for exactly
// one cycle two cycles after gnt[i]; there is no backpressure on the return.
module level_port_arbiter
    import lvl_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CW       = DEF_CW,
    parameter int TW       = DEF_TW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2:0]      req,
    input  logic [3*CW-1:0] req_x,
    input  logic [3*CW-1:0] req_y,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [TW-1:0]   rdata,
    output logic [CW-1:0]   lvl_x,
    output logic [CW-1:0]   lvl_y,
    input  logic [TW-1:0]   lvl_data,
    output logic [STAT_W-1:0] stat_disp,
    output logic [STAT_W-1:0] stat_ply,
    output logic [STAT_W-1:0] stat_bld
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] waitPly;
    logic [WAIT_W-1:0] waitBld;
    logic              rrPtr;
    logic              satPly;
    logic              satBld;
    logic              anySat;
    logic              pickPly;
    logic              pickBld;
    logic [1:0]        pickWin;
    logic              pickNext;
    logic              collGnt;
    logic [CW-1:0]     selX;
    logic [CW-1:0]     selY;
    logic [2:0]        s1Id;

    // A probe is starving only while it is still requesting.
    assign satPly = req[REQ_PLY] && (waitPly == WAIT_LIMIT);
    assign satBld = req[REQ_BLD] && (waitBld == WAIT_LIMIT);
    assign anySat = satPly || satBld;

    // One picker serves both paths: starving probes only, or all probes.
    assign pickPly = anySat ? satPly : req[REQ_PLY];
    assign pickBld = anySat ? satBld : req[REQ_BLD];

    lvl_rr_pick uPick (
        .reqA    (pickPly),
        .reqB    (pickBld),
        .ptr     (rrPtr),
        .win     (pickWin),
        .nextPtr (pickNext)
    );

    // Grant selection: starvation first, then display, then round-robin.
    always_comb begin
        gnt = 3'b000;
        if (!reset_n) begin
            gnt = 3'b000;
        end else if (anySat) begin
            gnt = {pickWin, 1'b0};
        end else if (req[REQ_DISP]) begin
            gnt = 3'b001;
        end else begin
            gnt = {pickWin, 1'b0};
        end
    end

    assign collGnt = gnt[REQ_PLY] || gnt[REQ_BLD];

    // Route the granted requester's coordinates into stage 1.
    always_comb begin
        selX = req_x[REQ_DISP*CW +: CW];
        selY = req_y[REQ_DISP*CW +: CW];
        if (gnt[REQ_PLY]) begin
            selX = req_x[REQ_PLY*CW +: CW];
            selY = req_y[REQ_PLY*CW +: CW];
        end else if (gnt[REQ_BLD]) begin
            selX = req_x[REQ_BLD*CW +: CW];
            selY = req_y[REQ_BLD*CW +: CW];
        end
    end

    // Wait counters and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waitPly <= '0;
            waitBld <= '0;
            rrPtr   <= 1'b0;
        end else begin
            if (!req[REQ_PLY] || gnt[REQ_PLY]) begin
                waitPly <= '0;
            end else if (waitPly != WAIT_LIMIT) begin
                waitPly <= waitPly + 1'b1;
            end
            if (!req[REQ_BLD] || gnt[REQ_BLD]) begin
                waitBld <= '0;
            end else if (waitBld != WAIT_LIMIT) begin
                waitBld <= waitBld + 1'b1;
            end
            if (collGnt) begin
                rrPtr <= pickNext;
            end
        end
    end

    // Stage 1: latch granted address and owner; level answers combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_x <= '0;
            lvl_y <= '0;
            s1Id  <= 3'b000;
        end else begin
            s1Id <= gnt;
            if (gnt != 3'b000) begin
                lvl_x <= selX;
                lvl_y <= selY;
            end
        end
    end

    // Stage 2: capture the block type and pulse the owner's rvalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid <= 3'b000;
            rdata  <= '0;
        end else begin
            rvalid <= s1Id;
            if (s1Id != 3'b000) begin
                rdata <= lvl_data;
            end
        end
    end

`ifdef LVL_ARB_STATS_EN
    logic [STAT_W-1:0] statCnt [3];

    // Per-requester grant counters, saturating, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                statCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (gnt[i] && (statCnt[i] != {STAT_W{1'b1}})) begin
                    statCnt[i] <= statCnt[i] + 1'b1;
                end
            end
        end
    end

    assign stat_disp = statCnt[REQ_DISP];
    assign stat_ply  = statCnt[REQ_PLY];
    assign stat_bld  = statCnt[REQ_BLD];
`else
    assign stat_disp = '0;
    assign stat_ply  = '0;
    assign stat_bld  = '0;
`endif

endmodule
